// File: rtl/ram_param_clr_pkg.sv
// Shared definitions for the zero-initialised parametrised RAM family.
// Default geometry matches the other memory blocks.
package ram_param_clr_pkg;

  localparam int unsigned DEF_WIDTH  = 16;
  localparam int unsigned DEF_ADDR_W = 14;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_e;

endpackage

// File: rtl/ram_clr_fsm.sv
// Clear engine: walks every address writing zero after reset or on request,
// and otherwise passes port A writes through to the array.
module ram_clr_fsm
  import ram_param_clr_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              clear,
  input  logic [ADDR_W-1:0] address,
  input  logic [WIDTH-1:0]  wr_data_in,
  output logic              busy,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [WIDTH-1:0]  wdata
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  clr_state_e        state_q, state_d;
  logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
  logic              busy_q, busy_d;

  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    busy_d     = busy_q;
    we         = 1'b0;
    waddr      = address;
    wdata      = wr_data_in;
    unique case (state_q)
      ST_CLEAR: begin
        // Requests and writes are ignored until the sweep finishes.
        we         = 1'b1;
        waddr      = clr_addr_q;
        wdata      = '0;
        clr_addr_d = clr_addr_q + ADDR_W'(1);
        if (clr_addr_q == LAST_ADDR) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
      end
      ST_IDLE: begin
        if (clear) begin
          state_d    = ST_CLEAR;
          clr_addr_d = '0;
          busy_d     = 1'b1;
        end else begin
          we = load;
        end
      end
      default: begin
        state_d    = ST_CLEAR;
        clr_addr_d = '0;
        busy_d     = 1'b1;
      end
    endcase
    // Nothing reaches the array on a reset edge; the sweep begins after release.
    if (!rst_n) begin
      we = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_CLEAR;
      clr_addr_q <= '0;
      busy_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      busy_q     <= busy_d;
    end
  end

  assign busy = busy_q;

endmodule

// File: rtl/ram_param_clr.sv
// Parametrised single-clock RAM with two asynchronous read ports and a
// hardware clear engine; reads return zero while the array is being cleared.
module ram_param_clr
  import ram_param_clr_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WIDTH-1:0]  in,
  input  logic              load,
  input  logic [ADDR_W-1:0] address,
  input  logic [ADDR_W-1:0] address_b,
  input  logic              clear,
  output logic [WIDTH-1:0]  out,
  output logic [WIDTH-1:0]  out_b,
  output logic              busy
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [WIDTH-1:0]  mem [DEPTH];
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [WIDTH-1:0]  wdata;

  ram_clr_fsm #(
    .WIDTH  (WIDTH),
    .ADDR_W (ADDR_W)
  ) u_clr_fsm (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .clear      (clear),
    .address    (address),
    .wr_data_in (in),
    .busy       (busy),
    .we         (we),
    .waddr      (waddr),
    .wdata      (wdata)
  );

  // No reset on the array itself: zeroing is done by the clear sweep.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign out   = busy ? '0 : mem[address];
  assign out_b = busy ? '0 : mem[address_b];

endmodule

// File: tb/tb_ram_param_clr.sv
// Directed bench for ram_param_clr (DEPTH=16 instance) plus a short
// model-checked run on the full 16K instance.
module tb_ram_param_clr;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] in;
  logic        load;
  logic [3:0]  address, address_b;
  logic        clear;
  logic [15:0] out, out_b;
  logic        busy;

  logic [15:0] big_in;
  logic        big_load;
  logic [13:0] big_address, big_address_b;
  logic        big_clear;
  logic [15:0] big_out, big_out_b;
  logic        big_busy;

  int total = 0;
  int bad   = 0;

  logic [15:0] model [16384];

  always #5 clk = ~clk;

  ram_param_clr #(.WIDTH(16), .ADDR_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in        (in),
    .load      (load),
    .address   (address),
    .address_b (address_b),
    .clear     (clear),
    .out       (out),
    .out_b     (out_b),
    .busy      (busy)
  );

  ram_param_clr #(.WIDTH(16), .ADDR_W(14)) dut_big (
    .clk       (clk),
    .rst_n     (rst_n),
    .in        (big_in),
    .load      (big_load),
    .address   (big_address),
    .address_b (big_address_b),
    .clear     (big_clear),
    .out       (big_out),
    .out_b     (big_out_b),
    .busy      (big_busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    for (int a = 0; a < 16; a++) begin
      address   = 4'(a);
      address_b = 4'(15 - a);
      #1;
      check({tag, "_a"}, {16'h0, out}, 32'h0);
      check({tag, "_b"}, {16'h0, out_b}, 32'h0);
    end
  endtask

  task automatic fill(input logic [15:0] val);
    load = 1'b1;
    in   = val;
    for (int a = 0; a < 16; a++) begin
      address = 4'(a);
      tick();
    end
    load = 1'b0;
  endtask

  // Expects busy high after each of the first n-1 edges and low after edge n.
  task automatic count_busy(input string tag, input int n);
    for (int i = 1; i <= n; i++) begin
      tick();
      check(tag, {31'h0, busy}, {31'h0, (i < n)});
      if (i < n) check({tag, "_out0"}, {16'h0, out}, 32'h0);
    end
  endtask

  initial begin
    int          waited;
    logic [13:0] ra;
    logic [15:0] rd;
    logic        rl;

    rst_n = 1'b0; in = 16'hBEEF; load = 1'b1; address = 4'd3; address_b = 4'd3; clear = 1'b0;
    big_in = '0; big_load = 1'b0; big_address = '0; big_address_b = '0; big_clear = 1'b0;
    for (int i = 0; i < 16384; i++) model[i] = '0;

    // 1: reset release, writes attempted throughout the clear
    tick();
    tick();
    check("rst_busy", {31'h0, busy}, 32'h1);
    check("rst_out", {16'h0, out}, 32'h0);
    rst_n = 1'b1;
    count_busy("rel_busy", 16);
    load = 1'b0;
    check_all_zero("rel_zero");

    // 2: write/read both ports
    load = 1'b1; address = 4'd5; in = 16'h1234;
    tick();
    check("wr_same_cycle", {16'h0, out}, 32'h1234);
    address = 4'd9; in = 16'hABCD;
    tick();
    load = 1'b0; address = 4'd5; address_b = 4'd9;
    #1;
    check("rd_a", {16'h0, out}, 32'h1234);
    check("rd_b", {16'h0, out_b}, 32'hABCD);
    address_b = 4'd5;
    #1;
    check("rd_same_addr", {16'h0, out_b}, 32'h1234);

    // 3: clear request colliding with a write
    fill(16'hFFFF);
    address = 4'd7;
    #1;
    check("fill_ffff", {16'h0, out}, 32'hFFFF);
    clear = 1'b1; load = 1'b1; address = 4'd2; in = 16'h0042;
    tick();
    clear = 1'b0; load = 1'b0;
    check("clr_busy_rise", {31'h0, busy}, 32'h1);
    count_busy("clr_busy", 16);
    address = 4'd2;
    #1;
    check("clr_write_dropped", {16'h0, out}, 32'h0);
    check_all_zero("clr_zero");

    // 4: reset during a clear restarts the sweep
    fill(16'h5555);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midrst_busy", {31'h0, busy}, 32'h1);
    count_busy("midrst_busy", 16);
    check_all_zero("midrst_zero");

    // 5: second clear pulse during a clear is ignored
    fill(16'h00A5);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      clear = (i == 4);
      tick();
      check("reclr_busy", {31'h0, busy}, {31'h0, (i < 16)});
    end
    clear = 1'b0;
    check_all_zero("reclr_zero");

    // 6: full-size instance against a reference model
    waited = 0;
    while (big_busy && waited < 20000) begin
      tick();
      waited++;
    end
    check("big_clear_done", {31'h0, big_busy}, 32'h0);
    for (int i = 0; i < 40; i++) begin
      rl = 1'($urandom_range(0, 1));
      ra = 14'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) ra = 14'($urandom);
      rd = 16'($urandom);
      big_load = rl; big_address = ra; big_in = rd; big_address_b = 14'($urandom_range(0, 15));
      tick();
      if (rl) model[ra] = rd;
      check("big_out", {16'h0, big_out}, {16'h0, model[ra]});
      check("big_out_b", {16'h0, big_out_b}, {16'h0, model[big_address_b]});
    end
    big_load = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
